// File: rtl/gb_timer_pkg.sv
// Shared constants for the Game Boy DIV/TIMA/TMA/TAC timer.
package gb_timer_pkg;

    localparam logic [1:0] TMR_DIV  = 2'd0;
    localparam logic [1:0] TMR_TIMA = 2'd1;
    localparam logic [1:0] TMR_TMA  = 2'd2;
    localparam logic [1:0] TMR_TAC  = 2'd3;

    // Divider bit sampled for each TAC clock select
    localparam logic [3:0] TAP_SEL00 = 4'd9;
    localparam logic [3:0] TAP_SEL01 = 4'd3;
    localparam logic [3:0] TAP_SEL10 = 4'd5;
    localparam logic [3:0] TAP_SEL11 = 4'd7;

    localparam logic [7:0] TAC_READ_MASK = 8'hF8;
    localparam logic [1:0] OVF_DELAY     = 2'd3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        OVF    = 2'd1,
        RELOAD = 2'd2
    } tmr_state_t;

    function automatic logic [3:0] tap_index(input logic [1:0] sel);
        logic [3:0] idx;
        idx = TAP_SEL00;
        case (sel)
            2'b00: idx = TAP_SEL00;
            2'b01: idx = TAP_SEL01;
            2'b10: idx = TAP_SEL10;
            2'b11: idx = TAP_SEL11;
            default: idx = TAP_SEL00;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/gb_timer.sv
// Game Boy timer: 16-bit divider, TIMA/TMA/TAC, delayed-reload overflow FSM, 1-clk irq.
// Reads are combinational, writes land next clk; no backpressure, one-clk write strobes.
module gb_timer
    import gb_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic [1:0] addr,
    input  logic       wr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq
);

    logic [15:0] r_div_cnt;
    logic [7:0]  r_tima;
    logic [7:0]  r_tma;
    logic [2:0]  r_tac;
    logic        r_tap_q;
    tmr_state_t  r_state;
    logic [1:0]  r_ovf_cnt;
    logic        r_irq;

    logic        w_wr_div;
    logic        w_wr_tima;
    logic        w_wr_tma;
    logic        w_wr_tac;
    logic        w_tap;
    logic        w_tick;
    logic [7:0]  w_tma_next;

    assign w_wr_div   = cs & wr & (addr == TMR_DIV);
    assign w_wr_tima  = cs & wr & (addr == TMR_TIMA);
    assign w_wr_tma   = cs & wr & (addr == TMR_TMA);
    assign w_wr_tac   = cs & wr & (addr == TMR_TAC);

    // A DIV clear or TAC change that drops the tap also counts as a tick
    assign w_tap      = r_tac[2] & r_div_cnt[tap_index(r_tac[1:0])];
    assign w_tick     = r_tap_q & ~w_tap;
    assign w_tma_next = w_wr_tma ? wdata : r_tma;

    assign irq = r_irq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= 16'h0000;
            r_tma     <= 8'h00;
            r_tac     <= 3'b000;
            r_tap_q   <= 1'b0;
        end else begin
            r_div_cnt <= w_wr_div ? 16'h0000 : r_div_cnt + 16'h0001;
            r_tap_q   <= w_tap;
            if (w_wr_tma) r_tma <= wdata;
            if (w_wr_tac) r_tac <= wdata[2:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tima    <= 8'h00;
            r_state   <= RUN;
            r_ovf_cnt <= 2'd0;
            r_irq     <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            case (r_state)
                RUN: begin
                    if (w_wr_tima) begin
                        r_tima <= wdata;
                    end else if (w_tick) begin
                        if (r_tima == 8'hFF) begin
                            r_tima    <= 8'h00;
                            r_ovf_cnt <= OVF_DELAY;
                            r_state   <= OVF;
                        end else begin
                            r_tima <= r_tima + 8'd1;
                        end
                    end
                end
                OVF: begin
                    if (w_wr_tima) begin
                        r_tima  <= wdata;
                        r_state <= RUN;
                    end else begin
                        r_ovf_cnt <= r_ovf_cnt - 2'd1;
                        if (r_ovf_cnt == 2'd1) begin
                            r_tima  <= w_tma_next;
                            r_irq   <= 1'b1;
                            r_state <= RELOAD;
                        end
                    end
                end
                RELOAD: begin
                    // TIMA writes and ticks are dropped; only a TMA write reaches TIMA here
                    if (w_wr_tma) r_tima <= wdata;
                    r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (addr)
            TMR_DIV:  rdata = r_div_cnt[15:8];
            TMR_TIMA: rdata = r_tima;
            TMR_TMA:  rdata = r_tma;
            TMR_TAC:  rdata = TAC_READ_MASK | {5'b00000, r_tac};
            default:  rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_gb_timer.sv
// Directed bench for gb_timer with hand-computed expectations.
module tb_gb_timer;
    import gb_timer_pkg::*;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       cs    = 1'b0;
    logic       wr    = 1'b0;
    logic [1:0] addr  = 2'd0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       irq;

    int n_cmp = 0;
    int n_mis = 0;

    gb_timer dut (
        .clk   (clk),
        .rst   (rst),
        .cs    (cs),
        .addr  (addr),
        .wr    (wr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        tick();
        cs = 1'b0; wr = 1'b0; wdata = 8'h00;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {7'd0, irq}, {7'd0, exp});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Timer on at 16 clks/inc, TIMA=0xFE one clk after a DIV clear; 32 clks later TIMA hits 0x00
    task automatic arm(input logic [7:0] tma);
        do_reset();
        wr_reg(TMR_TAC, 8'h05);
        wr_reg(TMR_TMA, tma);
        wr_reg(TMR_DIV, 8'h00);
        wr_reg(TMR_TIMA, 8'hFE);
    endtask

    task automatic count_irq(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (irq === 1'b1) cnt++;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;

        // Reset state
        ticks(2);
        chk_reg("rst_div",  TMR_DIV,  8'h00);
        chk_reg("rst_tima", TMR_TIMA, 8'h00);
        chk_reg("rst_tma",  TMR_TMA,  8'h00);
        chk_reg("rst_tac",  TMR_TAC,  8'hF8);
        chk_irq("rst_irq", 1'b0);

        // Free-running divider
        do_reset();
        ticks(511);
        chk_reg("div_511", TMR_DIV, 8'h01);
        tick();
        chk_reg("div_512", TMR_DIV, 8'h02);
        wr_reg(TMR_DIV, 8'h5A);
        chk_reg("div_clr", TMR_DIV, 8'h00);
        ticks(255);
        chk_reg("div_255", TMR_DIV, 8'h00);
        tick();
        chk_reg("div_256", TMR_DIV, 8'h01);

        // DIV clear with tap high bumps TIMA
        do_reset();
        wr_reg(TMR_DIV, 8'h00);
        wr_reg(TMR_TAC, 8'h05);
        chk_reg("tac_rd", TMR_TAC, 8'hFD);
        ticks(9);
        wr_reg(TMR_DIV, 8'h00);
        chk_reg("divclr_tima_pre", TMR_TIMA, 8'h00);
        tick();
        chk_reg("divclr_tima_inc", TMR_TIMA, 8'h01);

        // 256-clk period with TAC=0x07
        do_reset();
        wr_reg(TMR_TAC, 8'h07);
        wr_reg(TMR_DIV, 8'h00);
        ticks(256);
        chk_reg("p256_pre", TMR_TIMA, 8'h00);
        tick();
        chk_reg("p256_1", TMR_TIMA, 8'h01);
        ticks(255);
        chk_reg("p256_hold", TMR_TIMA, 8'h01);
        tick();
        chk_reg("p256_2", TMR_TIMA, 8'h02);

        // CPU write beats same-clk increment
        do_reset();
        wr_reg(TMR_TAC, 8'h05);
        wr_reg(TMR_DIV, 8'h00);
        wr_reg(TMR_TIMA, 8'h10);
        ticks(15);
        wr_reg(TMR_TIMA, 8'h77);
        chk_reg("wr_prio", TMR_TIMA, 8'h77);
        tick();
        chk_reg("wr_prio_hold", TMR_TIMA, 8'h77);

        // Overflow and reload timing
        arm(8'hF0);
        ticks(16);
        chk_reg("ovf_ff", TMR_TIMA, 8'hFF);
        ticks(15);
        chk_reg("ovf_ff_late", TMR_TIMA, 8'hFF);
        tick();
        chk_reg("ovf_n1", TMR_TIMA, 8'h00);
        chk_irq("ovf_n1_irq", 1'b0);
        tick();
        chk_reg("ovf_n2", TMR_TIMA, 8'h00);
        tick();
        chk_reg("ovf_n3", TMR_TIMA, 8'h00);
        chk_irq("ovf_n3_irq", 1'b0);
        tick();
        chk_irq("rld_irq", 1'b1);
        chk_reg("rld_tima", TMR_TIMA, 8'hF0);
        tick();
        chk_irq("rld_irq_off", 1'b0);
        chk_reg("rld_tima_hold", TMR_TIMA, 8'hF0);

        // TIMA write during OVF cancels reload
        arm(8'hF0);
        ticks(33);
        wr_reg(TMR_TIMA, 8'h33);
        chk_reg("ovfwr_tima", TMR_TIMA, 8'h33);
        count_irq(6, c);
        chk("ovfwr_irq_cnt", c[7:0], 8'd0);
        chk_reg("ovfwr_tima_hold", TMR_TIMA, 8'h33);

        // TIMA write in RELOAD clk is ignored
        arm(8'hF0);
        ticks(35);
        chk_irq("rldwr_irq", 1'b1);
        wr_reg(TMR_TIMA, 8'h33);
        chk_reg("rldwr_tima", TMR_TIMA, 8'hF0);
        chk_irq("rldwr_irq_off", 1'b0);

        // TMA write in RELOAD clk feeds TIMA
        arm(8'hF0);
        ticks(35);
        chk_irq("tmarld_irq", 1'b1);
        wr_reg(TMR_TMA, 8'h80);
        chk_reg("tmarld_tima", TMR_TIMA, 8'h80);
        chk_reg("tmarld_tma",  TMR_TMA,  8'h80);
        count_irq(8, c);
        chk("tmarld_irq_cnt", c[7:0], 8'd0);

        // Async reset mid-OVF
        arm(8'hF0);
        ticks(32);
        rst = 1'b0;
        #1;
        chk_reg("arst_div",  TMR_DIV,  8'h00);
        chk_reg("arst_tima", TMR_TIMA, 8'h00);
        chk_reg("arst_tma",  TMR_TMA,  8'h00);
        chk_reg("arst_tac",  TMR_TAC,  8'hF8);
        chk_irq("arst_irq", 1'b0);
        ticks(2);
        rst = 1'b1;
        count_irq(8, c);
        chk("arst_irq_cnt", c[7:0], 8'd0);
        chk_reg("arst_tima_after", TMR_TIMA, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/gb_timer.md
# gb_timer

Game Boy DIV/TIMA/TMA/TAC timer unit, instantiated inside the `Gameboy` top next to the IO register file. It decodes CPU accesses to 0xFF04–0xFF07 and runs the 16-bit system divider. It raises the timer interrupt request that feeds bit 2 of IF (0xFF0F) in the interrupt controller. Each `clk` is one T-cycle (4.194304 MHz nominal).

## Interface
- No parameters.
- `clk` in 1 — T-cycle clock.
- `rst` in 1 — asynchronous, active-low reset.
- `cs` in 1 — high when the CPU bus address is in 0xFF04–0xFF07.
- `addr` in 2 — register select: 0=DIV, 1=TIMA, 2=TMA, 3=TAC.
- `wr` in 1 — write strobe, qualified by `cs`, one clk per write.
- `wdata` in 8 — write data.
- `rdata` out 8 — combinational read data for `addr`. Value is independent of `cs`.
- `irq` out 1 — timer interrupt request, one-clk pulse.

## Operation
- **Divider `div_cnt[15:0]`**
  - Increments by 1 every clk and wraps 0xFFFF→0x0000.
  - Reading DIV returns `div_cnt[15:8]`.
  - Any DIV write, whatever the data, clears `div_cnt` to 0 in that clk.
- **TAC**
  - 3-bit register, written from `wdata[2:0]`. Reads as `{5'b11111, tac}`.
  - `tac[2]` is the timer enable.
  - `tac[1:0]` selects the tap bit: 00→bit 9, 01→bit 3, 10→bit 5, 11→bit 7.
- **Tick**
  - `tap = tac[2] & div_cnt[sel]`, with `tap_q` as its registered copy.
  - TIMA increments when `tap_q & ~tap`, i.e. on a falling edge.
  - Falling edges caused by a DIV clear or a TAC write also increment TIMA. This is intended hardware behaviour.
- **State machine**
  - **RUN**
    - An increment of TIMA from 0xFF sets TIMA to 0x00, loads `ovf_cnt` with 3, and moves to OVF.
  - **OVF**
    - TIMA reads 0x00.
    - `ovf_cnt` decrements each clk.
    - When `ovf_cnt` reaches 0, the FSM moves to RELOAD.
    - A CPU write to TIMA in OVF stores `wdata`, cancels the reload and the irq, and returns to RUN.
  - **RELOAD** (exactly one clk)
    - TIMA is loaded with TMA and `irq` = 1.
    - A TIMA write in this clk is ignored.
    - A TMA write in this clk updates TMA, and TIMA takes the new `wdata`.
    - Next state is RUN.
- **Write priority on TIMA in RUN:** a CPU write beats a same-clk increment.
- A TMA write takes effect next clk and has no other side effect.
- **Reset values** (asynchronous): `div_cnt`=0, TIMA=0, TMA=0, `tac`=0, `tap_q`=0, state=RUN, `ovf_cnt`=0, `irq`=0.
  - `rdata` after reset: DIV 0x00, TIMA 0x00, TMA 0x00, TAC 0xF8.
- Asserting reset mid-OVF discards the pending reload and produces no irq.

## Timing
- **Read latency:** zero. `rdata` is combinational from `addr` and the current register state.
- **Write latency:** a write in clk N is visible on `rdata` in clk N+1.
- **Overflow to irq:** the increment clk producing 0x00 is clk N. TIMA holds 0x00 for clks N+1..N+3. `irq` is high and TIMA=TMA in clk N+4.
- **TIMA period** from an aligned start with TMA=0, for sel 01/10/11/00: 16 / 64 / 256 / 1024 clks per increment.
- **`irq` width:** exactly one clk, never two back-to-back.

## Structure
- Package `gb_timer_pkg` holds:
  - Register offsets `TMR_DIV`, `TMR_TIMA`, `TMR_TMA`, `TMR_TAC`.
  - Tap-bit lookup constants.
  - State enum `{RUN, OVF, RELOAD}`.
  - `TAC_READ_MASK` = 0xF8.
- Single module with no sub-modules. The divider, edge detector and FSM are inline.
- The `Gameboy` top routes 0xFF04–0xFF07 here instead of `IORegisters`, and ORs `irq` into IF bit 2.

## Test plan
1. **Reset:** release `rst` and read all four registers → 0x00, 0x00, 0x00, 0xF8. `irq` is 0.
2. **TIMA reload:** write TAC=0x05 and TMA=0xF0, then write TIMA=0xFE right after a DIV write.
   - TIMA reaches 0x00 after 32 clks.
   - 4 clks later `irq` pulses for 1 clk and TIMA=0xF0.
3. **DIV behaviour:**
   - Free-run 512 clks from reset → DIV reads 0x02.
   - Write DIV=0x5A → DIV reads 0x00 next clk.
   - With TAC=0x05 and `div_cnt[3]`=1 at the time of the DIV write, TIMA increments by 1.
4. **TIMA write during OVF:**
   - Overflow TIMA, then 2 clks later write TIMA=0x33 → no `irq`, TIMA stays 0x33.
   - Repeat the write in the RELOAD clk → `irq` fires and TIMA=TMA.
5. **TMA write in RELOAD:** write TMA=0x80 in the RELOAD clk → TIMA=0x80 next clk and `irq` pulses once.
6. **Async reset mid-OVF:** assert `rst` 1 clk after an overflow → all registers reset immediately and no `irq` follows release.
